// File: rtl/branch_ctrl_pkg.sv
// Shared definitions for the branch controller: state encoding, opcode
// constants and the branch target table.
package branch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_DRAIN = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  localparam logic [3:0] OP_BR  = 4'b1111;  // conditional branch on flag
  localparam logic [3:0] OP_JMP = 4'b1110;  // unconditional jump

  // Branch destination PC for each 5-bit target-table index.
  localparam logic [9:0] TGT_LUT [0:31] = '{
    10'h000, 10'h012, 10'h025, 10'h037, 10'h04A, 10'h05C, 10'h06F, 10'h081,
    10'h094, 10'h0A6, 10'h0B9, 10'h0CB, 10'h0DE, 10'h0F0, 10'h103, 10'h115,
    10'h128, 10'h13A, 10'h14D, 10'h15F, 10'h172, 10'h184, 10'h197, 10'h1A9,
    10'h1BC, 10'h1CE, 10'h1E1, 10'h1F3, 10'h206, 10'h218, 10'h22B, 10'h3FF
  };

endpackage

// File: rtl/branch_ctrl_lut.sv
// Branch target lookup: maps the instruction's 5-bit table index to a
// 10-bit destination PC. Purely combinational.
module branch_lut
  import branch_ctrl_pkg::*;
(
  input  logic [4:0] idx,
  output logic [9:0] tgt
);

  // Table read; valid in every controller state.
  always_comb begin
    tgt = TGT_LUT[idx];
  end

endmodule

// File: rtl/branch_ctrl.sv
// Branch controller: program state machine (IDLE/RUN/DRAIN/DONE), compare
// flag register and branch request decode for the fetch unit.
// Optional feature: define BRANCH_TAKEN_CNT_EN to add the Taken_cnt port,
// a saturating count of taken branches.
module branch_ctrl
  import branch_ctrl_pkg::*;
(
  input  logic        CLK,
  input  logic        Init,
  input  logic        Start,
  input  logic        Halt,
  input  logic [8:0]  Instr,
  input  logic        Cmp_valid,
  input  logic        Cmp_result,
  output logic        Branch_en,
  output logic        FLAG_OUT,
  output logic [9:0]  Target,
  output logic [1:0]  ProgState,
  output logic        Done
`ifdef BRANCH_TAKEN_CNT_EN
  ,
  output logic [15:0] Taken_cnt
`endif
);

  state_e     state_r;
  state_e     next_state_s;
  logic       drain_cnt_r;   // set during the second DRAIN cycle
  logic       done_r;
  logic       flag_r;
  logic       start_acc_s;   // Start accepted this cycle (IDLE or DONE only)
  logic       branch_en_s;
  logic       flag_out_s;
  logic [3:0] opcode_s;

  assign opcode_s  = Instr[8:5];
  assign ProgState = state_r;
  assign Done      = done_r;
  assign Branch_en = branch_en_s;
  assign FLAG_OUT  = flag_out_s;

  branch_lut u_lut (
    .idx (Instr[4:0]),
    .tgt (Target)
  );

  // Next-state logic; Start only counts in IDLE/DONE, Halt only in RUN.
  always_comb begin
    next_state_s = state_r;
    start_acc_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (Start) begin
          next_state_s = ST_RUN;
          start_acc_s  = 1'b1;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (Halt) begin
          next_state_s = ST_DRAIN;
        end else begin
          next_state_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_r) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_DRAIN;
        end
      end
      ST_DONE: begin
        if (Start) begin
          next_state_s = ST_RUN;
          start_acc_s  = 1'b1;
        end else begin
          next_state_s = ST_DONE;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Branch request decode; the flag used is the registered (old) value.
  always_comb begin
    branch_en_s = 1'b0;
    flag_out_s  = 1'b0;
    if (state_r == ST_RUN) begin
      case (opcode_s)
        OP_BR: begin
          branch_en_s = 1'b1;
          flag_out_s  = flag_r;
        end
        OP_JMP: begin
          branch_en_s = 1'b1;
          flag_out_s  = 1'b1;
        end
        default: begin
          branch_en_s = 1'b0;
          flag_out_s  = 1'b0;
        end
      endcase
    end else begin
      branch_en_s = 1'b0;
      flag_out_s  = 1'b0;
    end
  end

  // State register, two-cycle drain timer and registered Done.
  always_ff @(posedge CLK) begin
    if (Init) begin
      state_r     <= ST_IDLE;
      drain_cnt_r <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      drain_cnt_r <= (state_r == ST_DRAIN) && !drain_cnt_r;
      done_r      <= (next_state_s == ST_DONE);
    end
  end

  // Compare flag: captured in RUN, cleared by an accepted Start.
  always_ff @(posedge CLK) begin
    if (Init) begin
      flag_r <= 1'b0;
    end else if (start_acc_s) begin
      flag_r <= 1'b0;
    end else if ((state_r == ST_RUN) && Cmp_valid) begin
      flag_r <= Cmp_result;
    end else begin
      flag_r <= flag_r;
    end
  end

`ifdef BRANCH_TAKEN_CNT_EN
  logic [15:0] taken_cnt_r;

  assign Taken_cnt = taken_cnt_r;

  // Saturating count of cycles where the PC actually loads Target.
  always_ff @(posedge CLK) begin
    if (Init) begin
      taken_cnt_r <= 16'h0000;
    end else if (start_acc_s) begin
      taken_cnt_r <= 16'h0000;
    end else if (branch_en_s && flag_out_s && (taken_cnt_r != 16'hFFFF)) begin
      taken_cnt_r <= taken_cnt_r + 16'h0001;
    end else begin
      taken_cnt_r <= taken_cnt_r;
    end
  end
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl. Each step drives inputs on the falling
// edge, queues the expected outputs and compares them 2 time units later.
// Build with BRANCH_TAKEN_CNT_EN to also cover Taken_cnt and saturation.
module tb_branch_ctrl;

  localparam logic [3:0] T_BR  = 4'b1111;
  localparam logic [3:0] T_JMP = 4'b1110;

  localparam logic [9:0] TB_LUT [0:31] = '{
    10'h000, 10'h012, 10'h025, 10'h037, 10'h04A, 10'h05C, 10'h06F, 10'h081,
    10'h094, 10'h0A6, 10'h0B9, 10'h0CB, 10'h0DE, 10'h0F0, 10'h103, 10'h115,
    10'h128, 10'h13A, 10'h14D, 10'h15F, 10'h172, 10'h184, 10'h197, 10'h1A9,
    10'h1BC, 10'h1CE, 10'h1E1, 10'h1F3, 10'h206, 10'h218, 10'h22B, 10'h3FF
  };

  typedef struct {
    logic [1:0]  ps;
    logic        done;
    logic        br;
    logic        fl;
    logic [9:0]  tgt;
    logic [15:0] cnt;
  } exp_t;

  logic        CLK;
  logic        Init;
  logic        Start;
  logic        Halt;
  logic [8:0]  Instr;
  logic        Cmp_valid;
  logic        Cmp_result;
  logic        Branch_en;
  logic        FLAG_OUT;
  logic [9:0]  Target;
  logic [1:0]  ProgState;
  logic        Done;
`ifdef BRANCH_TAKEN_CNT_EN
  logic [15:0] Taken_cnt;
`endif

  exp_t exp_q[$];
  int   n_checks;
  int   n_fails;
  int   step_no;

  branch_ctrl dut (
    .CLK        (CLK),
    .Init       (Init),
    .Start      (Start),
    .Halt       (Halt),
    .Instr      (Instr),
    .Cmp_valid  (Cmp_valid),
    .Cmp_result (Cmp_result),
    .Branch_en  (Branch_en),
    .FLAG_OUT   (FLAG_OUT),
    .Target     (Target),
    .ProgState  (ProgState),
    .Done       (Done)
`ifdef BRANCH_TAKEN_CNT_EN
    ,
    .Taken_cnt  (Taken_cnt)
`endif
  );

  // Free-running clock, period 10.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks = n_checks + 1;
    if (obs !== expv) begin
      n_fails = n_fails + 1;
      $display("FAIL %s at step %0d: got %0h, expected %0h", tag, step_no, obs, expv);
    end
  endtask

  // One cycle: drive inputs, queue expectation, compare mid-cycle.
  task automatic step(input logic i_init, input logic i_start, input logic i_halt,
                      input logic [8:0] i_instr, input logic i_cv, input logic i_cr,
                      input logic [1:0] e_ps, input logic e_done, input logic e_br,
                      input logic e_fl, input logic [15:0] e_cnt);
    exp_t e;
    @(negedge CLK);
    step_no    = step_no + 1;
    Init       = i_init;
    Start      = i_start;
    Halt       = i_halt;
    Instr      = i_instr;
    Cmp_valid  = i_cv;
    Cmp_result = i_cr;
    e.ps   = e_ps;
    e.done = e_done;
    e.br   = e_br;
    e.fl   = e_fl;
    e.tgt  = TB_LUT[i_instr[4:0]];
    e.cnt  = e_cnt;
    exp_q.push_back(e);
    #2;
    e = exp_q.pop_front();
    check_val("ProgState", {30'd0, ProgState}, {30'd0, e.ps});
    check_val("Done",      {31'd0, Done},      {31'd0, e.done});
    check_val("Branch_en", {31'd0, Branch_en}, {31'd0, e.br});
    check_val("FLAG_OUT",  {31'd0, FLAG_OUT},  {31'd0, e.fl});
    check_val("Target",    {22'd0, Target},    {22'd0, e.tgt});
`ifdef BRANCH_TAKEN_CNT_EN
    check_val("Taken_cnt", {16'd0, Taken_cnt}, {16'd0, e.cnt});
`endif
  endtask

  initial begin
    n_checks   = 0;
    n_fails    = 0;
    step_no    = 0;
    Init       = 1'b1;
    Start      = 1'b1;
    Halt       = 1'b0;
    Instr      = 9'd0;
    Cmp_valid  = 1'b0;
    Cmp_result = 1'b0;
    // Init held with Start for two edges.
    repeat (2) @(posedge CLK);

    //    init  start halt  instr              cv    cr    ps     done  br    fl    cnt
    step(1'b1, 1'b1, 1'b0, {T_BR, 5'd3},      1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 16'd0);
    step(1'b0, 1'b0, 1'b0, 9'd0,              1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 16'd0);
    step(1'b0, 1'b1, 1'b0, 9'd0,              1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 16'd0);
    step(1'b0, 1'b0, 1'b0, {4'b0000, 5'd5},   1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 16'd0);
    step(1'b0, 1'b0, 1'b0, {T_BR, 5'd3},      1'b0, 1'b0, 2'd1, 1'b0, 1'b1, 1'b1, 16'd0);
    // Compare result 0 arrives with the branch: old flag (1) still used.
    step(1'b0, 1'b0, 1'b0, {T_BR, 5'd3},      1'b1, 1'b0, 2'd1, 1'b0, 1'b1, 1'b1, 16'd1);
    step(1'b0, 1'b0, 1'b0, {T_BR, 5'd7},      1'b0, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0, 16'd2);
    // Flag 0, compare 1 with OP_BR in same cycle, then OP_BR held.
    step(1'b0, 1'b0, 1'b0, {T_BR, 5'd9},      1'b1, 1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 16'd2);
    step(1'b0, 1'b0, 1'b0, {T_BR, 5'd9},      1'b0, 1'b0, 2'd1, 1'b0, 1'b1, 1'b1, 16'd2);
    step(1'b0, 1'b0, 1'b0, {T_JMP, 5'd31},    1'b0, 1'b0, 2'd1, 1'b0, 1'b1, 1'b1, 16'd3);
    // Other opcode; Start in RUN ignored (flag must survive).
    step(1'b0, 1'b1, 1'b0, {4'b1101, 5'd1},   1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 16'd4);
    // Halt with a branch in the same cycle.
    step(1'b0, 1'b0, 1'b1, {T_BR, 5'd2},      1'b0, 1'b0, 2'd1, 1'b0, 1'b1, 1'b1, 16'd4);
    // DRAIN: two cycles, branches suppressed, Start and compare ignored.
    step(1'b0, 1'b1, 1'b0, {T_BR, 5'd4},      1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 16'd5);
    step(1'b0, 1'b0, 1'b0, {T_JMP, 5'd6},     1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 16'd5);
    // DONE: Halt ignored, Done high.
    step(1'b0, 1'b0, 1'b1, 9'd0,              1'b0, 1'b0, 2'd3, 1'b1, 1'b0, 1'b0, 16'd5);
    step(1'b0, 1'b0, 1'b0, {T_BR, 5'd8},      1'b0, 1'b0, 2'd3, 1'b1, 1'b0, 1'b0, 16'd5);
    step(1'b0, 1'b1, 1'b0, 9'd0,              1'b0, 1'b0, 2'd3, 1'b1, 1'b0, 1'b0, 16'd5);
    // Restarted: flag cleared, Done low, count cleared.
    step(1'b0, 1'b0, 1'b0, {T_BR, 5'd1},      1'b0, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0, 16'd0);
    // Abort from DRAIN, later Halt ignored in IDLE.
    step(1'b0, 1'b0, 1'b1, 9'd0,              1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 16'd0);
    step(1'b1, 1'b0, 1'b0, 9'd0,              1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 16'd0);
    step(1'b0, 1'b0, 1'b1, 9'd0,              1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 16'd0);
    step(1'b0, 1'b0, 1'b0, {T_JMP, 5'd10},    1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 16'd0);
    // Fresh drain after abort must still last exactly two cycles.
    step(1'b0, 1'b1, 1'b0, 9'd0,              1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 16'd0);
    step(1'b0, 1'b0, 1'b1, {T_JMP, 5'd20},    1'b0, 1'b0, 2'd1, 1'b0, 1'b1, 1'b1, 16'd0);
    step(1'b0, 1'b0, 1'b0, 9'd0,              1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 16'd1);
    step(1'b0, 1'b0, 1'b0, 9'd0,              1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 16'd1);
    // Init beats Start in DONE.
    step(1'b1, 1'b1, 1'b0, 9'd0,              1'b1, 1'b1, 2'd3, 1'b1, 1'b0, 1'b0, 16'd1);
    step(1'b0, 1'b0, 1'b0, {T_BR, 5'd0},      1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 16'd0);

`ifdef BRANCH_TAKEN_CNT_EN
    // Saturation: 65537 taken jumps, then an accepted Start clears it.
    step(1'b0, 1'b1, 1'b0, 9'd0,              1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 16'd0);
    for (int i = 0; i < 65537; i++) begin
      @(negedge CLK);
      Start = 1'b0;
      Instr = {T_JMP, 5'd12};
    end
    step(1'b0, 1'b0, 1'b1, 9'd0,              1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 16'hFFFF);
    step(1'b0, 1'b0, 1'b0, 9'd0,              1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 16'hFFFF);
    step(1'b0, 1'b0, 1'b0, 9'd0,              1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 16'hFFFF);
    step(1'b0, 1'b1, 1'b0, 9'd0,              1'b0, 1'b0, 2'd3, 1'b1, 1'b0, 1'b0, 16'hFFFF);
    step(1'b0, 1'b0, 1'b0, 9'd0,              1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 16'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/branch_ctrl.md
BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with these ports:
- CLK  in  1  clock; all state changes on the rising edge only.
- Init  in  1  synchronous active-high reset, sampled at the rising edge of CLK.
- Start  in  1  single-cycle pulse that launches a program.
- Halt  in  1  program-finished pulse from the fetch unit.
- Instr  in  9  current instruction: [8:5] opcode, [4:0] target-table index.
- Cmp_valid  in  1  the ALU compare result is valid this cycle.
- Cmp_result  in  1  ALU compare outcome.
- Branch_en  out  1  branch request to the fetch unit.
- FLAG_OUT  out  1  branch condition to the fetch unit; the PC loads Target when Branch_en and FLAG_OUT are both high.
- Target  out  10  branch destination PC.
- ProgState  out  2  current state encoding.
- Done  out  1  program complete.
- Taken_cnt  out  16  count of taken branches; this port exists only with the macro in REQ-015.

Function
REQ-002 The state machine SHALL have four states: IDLE=2'b00, RUN=2'b01, DRAIN=2'b10, DONE=2'b11; ProgState SHALL equal the state register.
REQ-003 Transitions:
- IDLE to RUN on Start.
- RUN to DRAIN on Halt.
- DRAIN to DONE after exactly 2 cycles in DRAIN.
- DONE to RUN on Start.
- All other inputs leave the state unchanged.
REQ-004 Start SHALL be ignored in RUN and DRAIN; Halt SHALL be ignored outside RUN.
REQ-005 Done SHALL be registered and high exactly while the state is DONE.
REQ-006 Flag register:
- Loaded with Cmp_result on a rising edge where Cmp_valid=1 and the state is RUN.
- Cleared to 0 on every accepted Start.
- Held otherwise.
REQ-007 Opcode 4'b1111 (conditional branch) in RUN SHALL drive Branch_en=1 and FLAG_OUT=flag register, combinationally.
REQ-008 Opcode 4'b1110 (jump) in RUN SHALL drive Branch_en=1 and FLAG_OUT=1, combinationally.
REQ-009 Any other opcode, or any state other than RUN, SHALL drive Branch_en=0 and FLAG_OUT=0.
REQ-010 Target SHALL equal TGT_LUT[Instr[4:0]] combinationally in every state. The table has 32 entries of 10 bits each.
REQ-011 A branch and a Cmp_valid in the same cycle: the branch SHALL use the old flag value; the new flag is visible from the next cycle.
REQ-012 A Halt and a branch in the same cycle: Branch_en SHALL still be asserted that cycle, and the state SHALL move to DRAIN at the edge.

Reset
REQ-013 Init=1 at a rising edge SHALL force:
- state IDLE (ProgState=0) and Done=0;
- flag register 0, so Branch_en=0 and FLAG_OUT=0;
- Taken_cnt=0.
Init SHALL take priority over Start, Halt and Cmp_valid in the same cycle.
REQ-014 Init asserted mid-operation (RUN, DRAIN or DONE) SHALL abort to IDLE at that edge, with no residual drain count.

Configuration
REQ-015 Macro BRANCH_TAKEN_CNT_EN:
- Defined: Taken_cnt exists. It increments by 1 at each edge where Branch_en=1 and FLAG_OUT=1, saturates at 16'hFFFF, clears on accepted Start and on Init, and holds in DRAIN, DONE and IDLE.
- Undefined: the port and the counter logic are absent, and all other behaviour is identical.

Structure
REQ-016 A shared package SHALL hold:
- the state enum;
- opcode constants OP_BR=4'b1111 and OP_JMP=4'b1110;
- the TGT_LUT constant array (32 entries of 10 bits).
REQ-017 The target table SHALL be a sub-module branch_lut: 5-bit index in, 10-bit Target out, purely combinational. branch_ctrl holds the state machine, the flag register and the counter.

Verification
REQ-018 Reset: hold Init=1 for 2 cycles with Start=1 -> ProgState=0, Done=0, Branch_en=0, Taken_cnt=0.
REQ-019 Conditional branch:
- Start, then Cmp_valid=1 with Cmp_result=1, then Instr=9'b1111_00011 -> Branch_en=1, FLAG_OUT=1, Target=TGT_LUT[3].
- Repeat with Cmp_result=0 -> Branch_en=1, FLAG_OUT=0.
REQ-020 Same-cycle compare: flag=0; Cmp_valid=1, Cmp_result=1 and Instr=OP_BR in the same cycle -> FLAG_OUT=0 that cycle, FLAG_OUT=1 the next cycle if OP_BR is held.
REQ-021 Halt sequence:
- In RUN, pulse Halt -> ProgState=2 for exactly 2 cycles, then ProgState=3 and Done=1.
- Start -> ProgState=1, Done=0, flag=0.
REQ-022 Abort: Init=1 while in DRAIN -> ProgState=0 next edge; a following Halt pulse is ignored.
REQ-023 With BRANCH_TAKEN_CNT_EN defined: 65537 consecutive taken OP_JMP cycles -> Taken_cnt=16'hFFFF; then Start -> Taken_cnt=0.
